// File: rtl/viol_event_logger_if.sv
// Host read port of the violation-timestamp FIFO: valid/ready pop of the head entry.
// Zero latency: signals only; the logger drives valid/data, the host drives ready.
interface viol_event_logger_if #(
    parameter int TS_W = 16
);
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_ts;

    modport master (output rd_valid, output rd_ts, input rd_ready);
    modport slave  (input rd_valid, input rd_ts, output rd_ready);
endinterface

// File: rtl/viol_event_logger.sv
// Re-checks !(a & c), with c = b delayed one clock; counts passes and violations and logs violation timestamps.
// Stats update on the evaluating edge; the FIFO pops on rd_valid & rd_ready, and a violation that finds it full is dropped.
module viol_event_logger #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 a,
    input  logic                 b,
    input  logic                 clr,
    viol_event_logger_if.master  rd,
    output logic [CNT_W-1:0]     viol_cnt,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic                 sticky_fail,
    output logic                 overflow,
    output logic                 c_q
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    logic viol;
    logic pass;
    logic empty;
    logic full;
    logic pop;
    logic push;

    assign viol  = en & a & c_q;
    assign pass  = en & ~viol;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & rd.rd_ready;
    // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
    assign push  = viol & (~full | pop);

    assign rd.rd_valid = ~empty;
    assign rd.rd_ts    = mem[rd_ptr[AW-1:0]];

    // Observation path: never gated by en or clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            ts  <= '0;
        end else begin
            c_q <= b;
            ts  <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            viol_cnt    <= '0;
            pass_cnt    <= '0;
            sticky_fail <= 1'b0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (viol) begin
                sticky_fail <= 1'b1;
                if (viol_cnt != '1)
                    viol_cnt <= viol_cnt + 1'b1;
                if (!push)
                    overflow <= 1'b1;
            end
            if (pass && pass_cnt != '1)
                pass_cnt <= pass_cnt + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push)
            mem[wr_ptr[AW-1:0]] <= ts;
    end
endmodule

// File: tb/tb_viol_event_logger.sv
// Directed bench: a vector table for reset/idle, single violation and enable gating, then
// hand-written sequences for overflow, clear priority and saturation/wrap on a narrow instance.
module tb_viol_event_logger;
    logic clk = 1'b0;
    logic rst, en, a, b, clr;

    logic [15:0] viol_cnt, pass_cnt;
    logic        sticky_fail, overflow, c_q;
    logic [3:0]  s_viol_cnt, s_pass_cnt;
    logic        s_sticky_fail, s_overflow, s_c_q;

    int n_checks = 0;
    int n_errors = 0;
    int ets      = 0;

    viol_event_logger_if #(.TS_W(16)) rd_if  ();
    viol_event_logger_if #(.TS_W(4))  rds_if ();

    viol_event_logger #(.CNT_W(16), .TS_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr), .rd(rd_if),
        .viol_cnt(viol_cnt), .pass_cnt(pass_cnt), .sticky_fail(sticky_fail),
        .overflow(overflow), .c_q(c_q)
    );

    viol_event_logger #(.CNT_W(4), .TS_W(4), .DEPTH(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr), .rd(rds_if),
        .viol_cnt(s_viol_cnt), .pass_cnt(s_pass_cnt), .sticky_fail(s_sticky_fail),
        .overflow(s_overflow), .c_q(s_c_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, a, b, clr, rdy;
        logic [15:0] viol, pass;
        logic        sticky, ovf, vld;
        logic [15:0] ts;
        logic        cq;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic e, input logic ai, input logic bi,
                                input logic c, input logic rdy, input int v, input int p,
                                input logic s, input logic o, input logic vl, input int t,
                                input logic q);
        vec_t x;
        x.rst = r; x.en = e; x.a = ai; x.b = bi; x.clr = c; x.rdy = rdy;
        x.viol = 16'(v); x.pass = 16'(p); x.sticky = s; x.ovf = o; x.vld = vl;
        x.ts = 16'(t); x.cq = q;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic ai, input logic bi,
                         input logic c, input logic rdy);
        rst = r; en = e; a = ai; b = bi; clr = c;
        rd_if.rd_ready  = rdy;
        rds_if.rd_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) ets = 0;
        else     ets = ets + 1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic expect_main(input string name, input int v, input int p, input logic s,
                               input logic o, input logic vl, input int t, input logic q);
        check({name, " viol_cnt"}, 32'(viol_cnt), 32'(v));
        check({name, " pass_cnt"}, 32'(pass_cnt), 32'(p));
        check({name, " sticky_fail"}, 32'(sticky_fail), 32'(s));
        check({name, " overflow"}, 32'(overflow), 32'(o));
        check({name, " rd_valid"}, 32'(rd_if.rd_valid), 32'(vl));
        if (vl)
            check({name, " rd_ts"}, 32'(rd_if.rd_ts), 32'(t));
        check({name, " c_q"}, 32'(c_q), 32'(q));
    endtask

    initial begin
        int pre;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset/idle: 10 enabled passes with a=1, b=0.
        repeat (2) vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 10; i++) vt.push_back(mk(0, 1, 1, 0, 0, 0, 0, i, 0, 0, 0, 0, 0));
        // Single violation: b=1 on the edge with ts=3, a=1 on the edge with ts=4.
        repeat (2) vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, i, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 1, 4, 1, 0, 1, 4, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0));
        // Enable gating: a=b=1 with en=0 counts nothing.
        repeat (2) vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (8) vt.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].en, vt[i].a, vt[i].b, vt[i].clr, vt[i].rdy);
            tick();
            expect_main($sformatf("row%0d", i), int'(vt[i].viol), int'(vt[i].pass),
                        vt[i].sticky, vt[i].ovf, vt[i].vld, int'(vt[i].ts), vt[i].cq);
        end

        // FIFO full/overflow: six violations logging ts 1..6, only 1..4 fit.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            expect_main($sformatf("ovf%0d", k), k, 0, 1'b1, (k > 4), 1'b1, 1, 1'b1);
        end
        // Pop during a violation at ts=7: head 1 leaves, 7 enters, still full.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        expect_main("pushpop", 7, 0, 1'b1, 1'b1, 1'b1, 2, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("drain1 rd_ts", 32'(rd_if.rd_ts), 32'd3);
        tick();
        check("drain2 rd_ts", 32'(rd_if.rd_ts), 32'd4);
        tick();
        check("drain3 rd_ts", 32'(rd_if.rd_ts), 32'd7);
        check("drain3 rd_valid", 32'(rd_if.rd_valid), 32'd1);
        tick();
        check("drain4 rd_valid", 32'(rd_if.rd_valid), 32'd0);
        tick();
        check("empty pop ignored", 32'(rd_if.rd_valid), 32'd0);

        // Clear priority over a same-edge violation; ts keeps running through it.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pre = ets;
        tick();
        expect_main("preclr", 8, 0, 1'b1, 1'b1, 1'b1, pre, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_main("clr", 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pre = ets;
        tick();
        expect_main("postclr", 1, 0, 1'b1, 1'b0, 1'b1, pre, 1'b1);

        // Saturation/wrap on the 4-bit instance; violation on the edge where ts has wrapped to 0.
        do_reset();
        for (int n = 1; n <= 21; n++) begin
            drive(1'b0, 1'b1, (n == 17), (n == 16), 1'b0, 1'b0);
            tick();
            if (n == 15) check("sat n15 pass_cnt", 32'(s_pass_cnt), 32'd15);
            if (n == 16) check("sat n16 pass_cnt", 32'(s_pass_cnt), 32'd15);
            if (n == 17) begin
                check("wrap viol_cnt", 32'(s_viol_cnt), 32'd1);
                check("wrap rd_valid", 32'(rds_if.rd_valid), 32'd1);
                check("wrap rd_ts", 32'(rds_if.rd_ts), 32'd0);
                check("wide rd_ts", 32'(rd_if.rd_ts), 32'd16);
            end
        end
        check("sat final pass_cnt", 32'(s_pass_cnt), 32'd15);
        check("sat sticky_fail", 32'(s_sticky_fail), 32'd1);
        check("sat overflow", 32'(s_overflow), 32'd0);
        check("sat c_q", 32'(s_c_q), 32'd0);
        check("wide final pass_cnt", 32'(pass_cnt), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
